keypad_scanner: RTL and testbench



---
 rtl/keypad_pkg.sv | 43 ++++
 rtl/keypad_scanner_col_sync.sv | 31 +++
 rtl/keypad_scanner.sv | 136 +++++++++++++
 tb/tb_keypad_scanner.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg
//   Shared types, sizes and helper functions for the 4x4 keypad scanner.
//   - NUM_ROWS / NUM_COLS / CODE_W : keypad geometry and key code width
//   - scan_state_t                 : scanner FSM states
//   - key_code_t                   : encoded key, row*4+col
//   - lowest_zero()                : index of the lowest active-low column
//   - encode_key()                 : row/column pattern -> key code
//   - row_drive()                  : row index -> active-low one-hot drive
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int CODE_W   = 4;

    typedef enum logic [1:0] {
        SCAN,
        CONFIRM,
        EMIT,
        WAIT_RELEASE
    } scan_state_t;

    typedef logic [CODE_W-1:0] key_code_t;

    // Scans from the top so the lowest pressed column is the last one written.
    function automatic logic [1:0] lowest_zero(input logic [NUM_COLS-1:0] cols);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = NUM_COLS - 1; i >= 0; i--) begin
            if (!cols[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    function automatic key_code_t encode_key(input logic [1:0]          row,
                                             input logic [NUM_COLS-1:0] cols);
        return {row, lowest_zero(cols)};
    endfunction

    function automatic logic [NUM_ROWS-1:0] row_drive(input logic [1:0] row);
        return ~(4'b0001 << row);
    endfunction

endpackage

// File: rtl/keypad_scanner_col_sync.sv
// col_sync
//   Two-flop synchronizer for the raw keypad columns, which change
//   asynchronously to clk. Resets to all ones (no key pressed).
//   Ports:
//     clk  - system clock
//     rst  - synchronous reset, active-high
//     din  - raw active-low columns
//     dout - synchronized columns, two cycles behind din
module col_sync
    import keypad_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_COLS-1:0] din,
    output logic [NUM_COLS-1:0] dout
);

    logic [NUM_COLS-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '1;
            dout <= '1;
        end else begin
            // NOTE: non-blocking so meta and dout stay two distinct flop stages.
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 active-low matrix keypad one row at a time, confirms a
//   stable single press, and hands out one key code per press over a
//   valid/ready handshake. A key is re-armed only after a stable release.
//   Parameters:
//     SCAN_TICKS - cycles each row is driven before its columns are sampled
//     STABLE_CNT - consecutive matching cycles to confirm a press or release
//   Ports:
//     clk       - system clock
//     rst       - synchronous reset, active-high
//     col_in    - raw columns, active-low, asynchronous
//     row_out   - row drive, active-low one-hot
//     key_code  - encoded key, row*4+col (lowest column wins)
//     key_valid - key_code holds a confirmed press
//     key_ready - consumer accepts key_code
//     key_held  - a confirmed key has not yet been released
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_TICKS = 4,
    parameter int STABLE_CNT = 26
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_COLS-1:0] col_in,
    output logic [NUM_ROWS-1:0] row_out,
    output key_code_t           key_code,
    output logic                key_valid,
    input  logic                key_ready,
    output logic                key_held
);

    localparam logic [7:0] TICK_LAST   = 8'(SCAN_TICKS - 1);
    localparam logic [7:0] STABLE_LAST = 8'(STABLE_CNT - 1);

    logic [NUM_COLS-1:0] cols;
    scan_state_t         state;
    logic [1:0]          row;
    logic [1:0]          next_row;
    logic [7:0]          tick;
    logic [7:0]          stable;
    logic [NUM_COLS-1:0] pattern;

    col_sync u_col_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (col_in),
        .dout (cols)
    );

    // Two-bit row index wraps 3 -> 0 on its own.
    assign next_row = row + 2'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SCAN;
            row       <= 2'd0;
            row_out   <= row_drive(2'd0);
            tick      <= 8'd0;
            stable    <= 8'd0;
            pattern   <= '1;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            case (state)
                SCAN: begin
                    if (tick == TICK_LAST) begin
                        tick <= 8'd0;
                        if (cols != '1) begin
                            pattern <= cols;
                            stable  <= 8'd0;
                            state   <= CONFIRM;
                        end else begin
                            row     <= next_row;
                            row_out <= row_drive(next_row);
                        end
                    end else begin
                        tick <= tick + 8'd1;
                    end
                end

                CONFIRM: begin
                    if (cols == pattern) begin
                        if (stable == STABLE_LAST) begin
                            // Code is captured here and frozen until the handshake.
                            key_code  <= encode_key(row, pattern);
                            key_valid <= 1'b1;
                            key_held  <= 1'b1;
                            stable    <= 8'd0;
                            state     <= EMIT;
                        end else begin
                            stable <= stable + 8'd1;
                        end
                    end else begin
                        // Bounce or pattern change: abandon and move on.
                        stable  <= 8'd0;
                        tick    <= 8'd0;
                        row     <= next_row;
                        row_out <= row_drive(next_row);
                        state   <= SCAN;
                    end
                end

                EMIT: begin
                    // Column activity is ignored here; the press is delivered regardless.
                    if (key_ready) begin
                        key_valid <= 1'b0;
                        stable    <= 8'd0;
                        state     <= WAIT_RELEASE;
                    end
                end

                WAIT_RELEASE: begin
                    if (cols == '1) begin
                        if (stable == STABLE_LAST) begin
                            key_held <= 1'b0;
                            stable   <= 8'd0;
                            tick     <= 8'd0;
                            row      <= next_row;
                            row_out  <= row_drive(next_row);
                            state    <= SCAN;
                        end else begin
                            stable <= stable + 8'd1;
                        end
                    end else begin
                        stable <= 8'd0;
                    end
                end

                default: state <= SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
//   Directed bench for keypad_scanner with SCAN_TICKS=4, STABLE_CNT=8.
//   A small keypad model pulls a column low when its key is pressed and
//   its row is driven. Outputs are sampled on the falling clock edge.
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] col_in;
    logic [3:0] row_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic       key_held;

    logic [3:0] key_mask [4];
    logic       bounce_high;

    int tests_run    = 0;
    int tests_failed = 0;
    int xfer_count   = 0;

    keypad_scanner #(
        .SCAN_TICKS (4),
        .STABLE_CNT (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .col_in    (col_in),
        .row_out   (row_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a pressed key shorts its column to its driven (low) row.
    always_comb begin
        col_in = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            if (row_out[r] === 1'b0) col_in = ~key_mask[r];
        end
        if (bounce_high) col_in = 4'b1111;
    end

    always @(posedge clk) begin
        if (!rst && key_valid && key_ready) xfer_count <= xfer_count + 1;
    end

    task automatic fail_msg(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_failed++;
        $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_valid(input int limit, input string name);
        int n = 0;
        while (key_valid !== 1'b1 && n < limit) begin
            cycle();
            n++;
        end
        tests_run++;
        if (key_valid !== 1'b1) fail_msg(name, 32'(key_valid), 32'd1);
    endtask

    task automatic wait_released(input int limit, input string name);
        int n = 0;
        while (key_held !== 1'b0 && n < limit) begin
            cycle();
            n++;
        end
        tests_run++;
        if (key_held !== 1'b0) fail_msg(name, 32'(key_held), 32'd0);
    endtask

    task automatic clear_keys();
        for (int r = 0; r < 4; r++) key_mask[r] = 4'b0000;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (row_out !== 4'b1110) fail_msg("reset_row_out", 32'(row_out), 32'hE);
        tests_run++;
        if (key_valid !== 1'b0 || key_held !== 1'b0)
            fail_msg("reset_valid_held", {30'd0, key_valid, key_held}, 32'd0);
        tests_run++;
        if (key_code !== 4'd0) fail_msg("reset_key_code", 32'(key_code), 32'd0);
        rst = 1'b0;
    endtask

    task automatic test_idle_rotation();
        logic [3:0] exp_rows [4];
        exp_rows[0] = 4'b1110;
        exp_rows[1] = 4'b1101;
        exp_rows[2] = 4'b1011;
        exp_rows[3] = 4'b0111;
        for (int i = 0; i < 20; i++) begin
            tests_run++;
            if (row_out !== exp_rows[(i / 4) % 4])
                fail_msg($sformatf("idle_row_cycle_%0d", i), 32'(row_out), 32'(exp_rows[(i / 4) % 4]));
            if (key_valid !== 1'b0) begin
                tests_run++;
                fail_msg("idle_key_valid", 32'(key_valid), 32'd0);
            end
            cycle();
        end
    endtask

    task automatic test_clean_press();
        int base;
        int held_bad;
        base      = xfer_count;
        key_ready = 1'b1;
        key_mask[1] = 4'b0100;
        wait_valid(200, "press6_valid_timeout");
        tests_run++;
        if (key_code !== 4'd6) fail_msg("press6_code", 32'(key_code), 32'd6);
        tests_run++;
        if (key_held !== 1'b1) fail_msg("press6_held_on_emit", 32'(key_held), 32'd1);
        cycle();
        tests_run++;
        if (key_valid !== 1'b0) fail_msg("press6_single_pulse", 32'(key_valid), 32'd0);
        held_bad = 0;
        for (int i = 0; i < 30; i++) begin
            if (key_held !== 1'b1 || key_valid !== 1'b0) held_bad++;
            cycle();
        end
        tests_run++;
        if (held_bad != 0) fail_msg("press6_held_while_pressed", 32'(held_bad), 32'd0);
        tests_run++;
        if (xfer_count != base + 1) fail_msg("press6_one_transfer", 32'(xfer_count - base), 32'd1);
        // Release: 2 sync cycles plus STABLE_CNT confirmation cycles.
        key_mask[1] = 4'b0000;
        repeat (9) cycle();
        tests_run++;
        if (key_held !== 1'b1) fail_msg("press6_held_before_release_done", 32'(key_held), 32'd1);
        cycle();
        tests_run++;
        if (key_held !== 1'b0) fail_msg("press6_released", 32'(key_held), 32'd0);
        tests_run++;
        if (row_out !== 4'b1011) fail_msg("press6_resume_row2", 32'(row_out), 32'hB);
    endtask

    task automatic test_bounce();
        int base;
        int valid_seen;
        int onehot_bad;
        logic [3:0] rows_seen;
        base       = xfer_count;
        valid_seen = 0;
        onehot_bad = 0;
        rows_seen  = 4'b0000;
        key_ready  = 1'b1;
        key_mask[1] = 4'b0100;
        for (int i = 0; i < 90; i++) begin
            if (i % 3 == 0) bounce_high = ~bounce_high;
            cycle();
            if (key_valid === 1'b1) valid_seen++;
            if ($countones(~row_out) != 1) onehot_bad++;
            rows_seen = rows_seen | ~row_out;
        end
        bounce_high = 1'b0;
        key_mask[1] = 4'b0000;
        repeat (40) begin
            cycle();
            if (key_valid === 1'b1) valid_seen++;
        end
        tests_run++;
        if (valid_seen != 0) fail_msg("bounce_no_valid", 32'(valid_seen), 32'd0);
        tests_run++;
        if (xfer_count != base) fail_msg("bounce_no_transfer", 32'(xfer_count - base), 32'd0);
        tests_run++;
        if (rows_seen !== 4'b1111) fail_msg("bounce_rows_advance", 32'(rows_seen), 32'hF);
        tests_run++;
        if (onehot_bad != 0) fail_msg("bounce_row_onehot", 32'(onehot_bad), 32'd0);
        tests_run++;
        if (key_held !== 1'b0) fail_msg("bounce_not_held", 32'(key_held), 32'd0);
    endtask

    task automatic test_backpressure();
        int base;
        int stall_bad;
        base      = xfer_count;
        key_ready = 1'b0;
        key_mask[3] = 4'b1000;
        wait_valid(200, "bp_valid_timeout");
        tests_run++;
        if (key_code !== 4'd15) fail_msg("bp_code", 32'(key_code), 32'd15);
        stall_bad = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (key_valid !== 1'b1 || key_code !== 4'd15) stall_bad++;
        end
        tests_run++;
        if (stall_bad != 0) fail_msg("bp_stable_while_stalled", 32'(stall_bad), 32'd0);
        tests_run++;
        if (xfer_count != base) fail_msg("bp_no_transfer_while_stalled", 32'(xfer_count - base), 32'd0);
        key_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        key_ready = 1'b0;
        tests_run++;
        if (key_valid !== 1'b0) fail_msg("bp_valid_drops", 32'(key_valid), 32'd0);
        tests_run++;
        if (xfer_count != base + 1) fail_msg("bp_one_transfer", 32'(xfer_count - base), 32'd1);
        key_mask[3] = 4'b0000;
        wait_released(40, "bp_release_timeout");
    endtask

    task automatic test_multi_key_hold();
        int base;
        int valid_seen;
        base        = xfer_count;
        valid_seen  = 0;
        key_ready   = 1'b1;
        // col_in = 1010 on row 0: columns 0 and 2 pressed, column 0 wins.
        key_mask[0] = 4'b0101;
        wait_valid(200, "multi_valid_timeout");
        tests_run++;
        if (key_code !== 4'd0) fail_msg("multi_code", 32'(key_code), 32'd0);
        for (int i = 0; i < 200; i++) begin
            cycle();
            if (key_valid === 1'b1) valid_seen++;
        end
        tests_run++;
        if (valid_seen != 0) fail_msg("hold_no_repeat_valid", 32'(valid_seen), 32'd0);
        tests_run++;
        if (xfer_count != base + 1) fail_msg("hold_one_event", 32'(xfer_count - base), 32'd1);
        tests_run++;
        if (key_held !== 1'b1) fail_msg("hold_still_held", 32'(key_held), 32'd1);
        key_mask[0] = 4'b0000;
        wait_released(40, "multi_release_timeout");
    endtask

    task automatic test_reset_mid_emit();
        int base;
        int valid_seen;
        key_ready   = 1'b0;
        key_mask[2] = 4'b0001;
        wait_valid(200, "rst_emit_valid_timeout");
        tests_run++;
        if (key_code !== 4'd8) fail_msg("rst_emit_code", 32'(key_code), 32'd8);
        rst = 1'b1;
        clear_keys();
        cycle();
        tests_run++;
        if (key_valid !== 1'b0 || key_held !== 1'b0)
            fail_msg("rst_emit_valid_held", {30'd0, key_valid, key_held}, 32'd0);
        tests_run++;
        if (row_out !== 4'b1110) fail_msg("rst_emit_row_out", 32'(row_out), 32'hE);
        rst        = 1'b0;
        key_ready  = 1'b1;
        base       = xfer_count;
        valid_seen = 0;
        for (int i = 0; i < 100; i++) begin
            cycle();
            if (key_valid === 1'b1) valid_seen++;
        end
        tests_run++;
        if (valid_seen != 0 || xfer_count != base)
            fail_msg("rst_emit_no_stale_event", 32'(valid_seen), 32'd0);
        key_mask[2] = 4'b0001;
        wait_valid(200, "rst_new_press_timeout");
        tests_run++;
        if (key_code !== 4'd8) fail_msg("rst_new_press_code", 32'(key_code), 32'd8);
        cycle();
        tests_run++;
        if (xfer_count != base + 1) fail_msg("rst_new_press_transfer", 32'(xfer_count - base), 32'd1);
        key_mask[2] = 4'b0000;
        wait_released(40, "rst_new_release_timeout");
    endtask

    initial begin
        rst         = 1'b1;
        key_ready   = 1'b0;
        bounce_high = 1'b0;
        clear_keys();
        test_reset();
        test_idle_rotation();
        test_clean_press();
        test_bounce();
        test_backpressure();
        test_multi_key_hold();
        test_reset_mid_emit();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
